// File: rtl/alu_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_scheduler_pkg
// Description : Shared types and constants for the round-robin ALU scheduler:
//               ALU opcode encoding, scheduler FSM states, divide-by-zero
//               bypass result and opcode width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_rr_scheduler_pkg;

    localparam int OPCODE_W = 3;

    // Result returned for DIV by zero without starting the ALU
    localparam logic [7:0] DIV_ZERO_RESULT = 8'hFF;

    typedef enum logic [OPCODE_W-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        MUL = 3'd2,
        DIV = 3'd3,
        MOD = 3'd4
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_t;

endpackage : alu_rr_scheduler_pkg
`default_nettype wire

// File: rtl/alu_rr_scheduler_rr_arbiter_oh.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter_oh
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one position above the pointer, wrapping
//               modulo N, and returns a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter_oh #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    // First set request after ptr wins; the last-served position has lowest priority
    always_comb begin
        logic             w_found;
        logic [IDX_W-1:0] w_pos;
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int i = 1; i <= N; i++) begin
            w_pos = IDX_W'((int'(ptr) + i) % N);
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                grant[w_pos] = 1'b1;
                idx          = w_pos;
            end
        end
    end

endmodule : rr_arbiter_oh
`default_nettype wire

// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_rr_scheduler
// Description : Shares one registered 8-bit ALU between NUM_REQ requesters
//               with round-robin arbitration and a single operation in
//               flight. DIV/MOD by zero are answered without the ALU.
//               Optional statistics counters (op_count, dz_count) are built
//               when ALU_SCHED_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rr_scheduler
    import alu_rr_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ALU_LATENCY = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [8*NUM_REQ-1:0]    req_a,
    input  logic [8*NUM_REQ-1:0]    req_b,
    input  logic [3*NUM_REQ-1:0]    req_op,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [7:0]              rsp_data,
    output logic                    rsp_dz,
    output logic                    alu_start,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    output logic [OPCODE_W-1:0]     alu_mode,
`ifdef ALU_SCHED_STATS_EN
    output logic [15:0]             op_count,
    output logic [7:0]              dz_count,
`endif
    input  logic [7:0]              alu_c
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(ALU_LATENCY + 1);

    sched_state_t        r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_gnt_idx;
    logic [CNT_W-1:0]    r_cnt;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [IDX_W-1:0]    w_idx;
    logic [7:0]          w_sel_a;
    logic [7:0]          w_sel_b;
    logic [OPCODE_W-1:0] w_sel_op;
    logic                w_bypass;
    logic                w_rsp_fire;

    rr_arbiter_oh #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_gnt),
        .idx   (w_idx)
    );

    // Operand/opcode of the granted requester, selected by the one-hot grant
    always_comb begin
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a  = w_sel_a  | req_a[8*i +: 8];
                w_sel_b  = w_sel_b  | req_b[8*i +: 8];
                w_sel_op = w_sel_op | req_op[OPCODE_W*i +: OPCODE_W];
            end
        end
        w_bypass = ((w_sel_op == DIV) || (w_sel_op == MOD)) && (w_sel_b == 8'd0);
    end

    // Accept is combinational in IDLE only; forced low while reset is held
    always_comb begin
        req_ready = (r_state == IDLE && reset_n) ? w_gnt : '0;
    end

    // Response handshake; rsp_valid is non-zero only in RESP and holds the grant
    assign w_rsp_fire = |(rsp_valid & rsp_ready);

    // Scheduler FSM with registered ALU-side and response-side outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_gnt_idx <= '0;
            r_cnt     <= '0;
            alu_start <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mode  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_dz    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_gnt_idx <= w_idx;
                        if (w_bypass) begin
                            r_state   <= RESP;
                            rsp_valid <= w_gnt;
                            rsp_dz    <= 1'b1;
                            rsp_data  <= (w_sel_op == DIV) ? DIV_ZERO_RESULT : w_sel_a;
                        end else begin
                            r_state   <= EXEC;
                            r_cnt     <= CNT_W'(ALU_LATENCY);
                            alu_start <= 1'b1;
                            alu_a     <= w_sel_a;
                            alu_b     <= w_sel_b;
                            alu_mode  <= w_sel_op;
                        end
                    end
                end
                EXEC: begin
                    alu_start <= 1'b0;
                    if (r_cnt == '0) begin
                        r_state   <= RESP;
                        rsp_data  <= alu_c;
                        rsp_dz    <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
                        alu_a     <= '0;
                        alu_b     <= '0;
                        alu_mode  <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_fire) begin
                        r_state   <= IDLE;
                        r_ptr     <= r_gnt_idx;
                        rsp_valid <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    // Saturating counters of completed responses and of divide-by-zero responses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_count <= '0;
            dz_count <= '0;
        end else if (w_rsp_fire) begin
            if (op_count != 16'hFFFF) begin
                op_count <= op_count + 16'd1;
            end
            if (rsp_dz && dz_count != 8'hFF) begin
                dz_count <= dz_count + 8'd1;
            end
        end
    end
`endif

endmodule : alu_rr_scheduler
`default_nettype wire

// File: tb/tb_alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_rr_scheduler
// Description : Self-checking bench for alu_rr_scheduler. A behavioural
//               registered ALU drives alu_c; a scoreboard queue holds the
//               expected response for every accepted request.
//               Checks op_count/dz_count when ALU_SCHED_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_rr_scheduler;
    import alu_rr_scheduler_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int ALU_LATENCY = 1;

    typedef struct {
        int         idx;
        logic [7:0] data;
        logic       dz;
    } exp_t;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [3*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [NUM_REQ-1:0]   rsp_ready;
    logic [7:0]           rsp_data;
    logic                 rsp_dz;
    logic                 alu_start;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [2:0]           alu_mode;
    logic [7:0]           alu_c = 8'd0;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]          op_count;
    logic [7:0]           dz_count;
`endif

    int   n_vec  = 0;
    int   n_fail = 0;
    int   alu_starts = 0;
    exp_t sb[$];
    int   gnt_log[$];

    alu_rr_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .ALU_LATENCY (ALU_LATENCY)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_dz    (rsp_dz),
        .alu_start (alu_start),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mode  (alu_mode),
`ifdef ALU_SCHED_STATS_EN
        .op_count  (op_count),
        .dz_count  (dz_count),
`endif
        .alu_c     (alu_c)
    );

    always #5 clock = ~clock;

    // Behavioural ALU: unknown opcodes return a XOR b
    function automatic logic [7:0] alu_fn(logic [2:0] m, logic [7:0] a, logic [7:0] b);
        case (m)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return 8'((16'(a) * 16'(b)) & 16'hFF);
            3'd3:    return (b == 0) ? 8'h00 : a / b;
            3'd4:    return (b == 0) ? 8'h00 : a % b;
            default: return a ^ b;
        endcase
    endfunction

    // Registered ALU result, one clock after operands
    always @(posedge clock) alu_c <= alu_fn(alu_mode, alu_a, alu_b);

    // Expected scheduler response {dz, data}
    function automatic logic [8:0] ref_result(logic [2:0] op, logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            3'd0:    return {1'b0, 8'(a + b)};
            3'd1:    return {1'b0, 8'(a - b)};
            3'd2:    return {1'b0, p[7:0]};
            3'd3:    return (b == 0) ? {1'b1, 8'hFF} : {1'b0, 8'(a / b)};
            3'd4:    return (b == 0) ? {1'b1, a}     : {1'b0, 8'(a % b)};
            default: return {1'b0, 8'(a ^ b)};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observe handshakes at the sampling point; push on accept, pop on response
    task automatic monitor();
        logic [NUM_REQ-1:0] hs;
        exp_t e;
        logic [8:0] r;
        hs = req_valid & req_ready;
        if (hs != '0) begin
            check("req_ready_onehot", 32'($countones(req_ready)), 32'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) begin
                    r = ref_result(req_op[3*i +: 3], req_a[8*i +: 8], req_b[8*i +: 8]);
                    e.idx  = i;
                    e.data = r[7:0];
                    e.dz   = r[8];
                    sb.push_back(e);
                    gnt_log.push_back(i);
                end
            end
        end
        if (alu_start) alu_starts++;
        if (|(rsp_valid & rsp_ready)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid_onehot", 32'(rsp_valid), 32'd1 << e.idx);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_dz", 32'(rsp_dz), 32'(e.dz));
            end
        end
    endtask

    task automatic sample();
        @(negedge clock);
        monitor();
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8]  = a;
        req_b[8*i +: 8]  = b;
        req_op[3*i +: 3] = op;
        req_valid[i]     = 1'b1;
    endtask

    task automatic wait_rsp(input int i, output int lat);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            sample();
            if (rsp_valid[i]) begin
                lat = k;
                break;
            end
            advance();
        end
        if (lat < 0) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        advance();
        advance();
        reset_n = 1'b1;
        sb.delete();
        gnt_log.delete();
    endtask

    // Single request from requester i, checks grant, latency and ALU start count
    task automatic do_single(input int i, input logic [2:0] op, input logic [7:0] a,
                             input logic [7:0] b, input int exp_lat, input int exp_starts);
        int lat;
        int s0;
        set_req(i, op, a, b);
        sample();
        check("grant", 32'(req_ready), 32'd1 << i);
        s0 = alu_starts;
        advance();
        req_valid[i] = 1'b0;
        wait_rsp(i, lat);
        check("latency", 32'(lat), 32'(exp_lat));
        check("alu_start_pulses", 32'(alu_starts - s0), 32'(exp_starts));
        advance();
    endtask

    initial begin
        int lat;
        int cnt;
        int exp_g[5];
        exp_g = '{0, 1, 2, 3, 0};

        reset_n   = 1'b0;
        req_valid = 4'b0001;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = '1;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_alu_ops", {8'd0, alu_a, alu_b, 5'd0, alu_mode}, 32'd0);
        check("rst_rsp", {23'd0, rsp_dz, rsp_data}, 32'd0);
        req_valid = '0;
        advance();
        reset_n = 1'b1;
        advance();

        // Single ADD
        do_single(0, ADD, 8'd20, 8'd22, 3, 1);

        // Round-robin fairness from a fresh pointer
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, SUB, 8'd5, 8'd7);
        for (int k = 0; k < 60 && gnt_log.size() < 5; k++) begin
            sample();
            advance();
        end
        req_valid = '0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            sample();
            advance();
        end
        check("rr_drain", 32'(sb.size()), 32'd0);
        check("rr_grants", 32'(gnt_log.size()), 32'd5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++) begin
            check("rr_order", 32'(gnt_log[k]), 32'(exp_g[k]));
        end

        // Divide / modulo by zero bypass
        do_single(2, DIV, 8'd9, 8'd0, 1, 0);
        do_single(2, MOD, 8'd9, 8'd0, 1, 0);

        // Response backpressure with a waiting requester
        rsp_ready = '0;
        set_req(1, MUL, 8'd12, 8'd11);
        sample();
        check("bp_grant", 32'(req_ready), 32'b0010);
        advance();
        req_valid[1] = 1'b0;
        set_req(3, ADD, 8'd3, 8'd4);
        rsp_ready = 4'b1000;
        wait_rsp(1, lat);
        check("bp_latency", 32'(lat), 32'd3);
        for (int j = 0; j < 5; j++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'b0010);
            check("bp_hold_data", 32'(rsp_data), 32'd132);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            advance();
            if (j == 4) rsp_ready = 4'b1010;
            sample();
        end
        check("bp_no_grant_in_resp", 32'(req_ready), 32'd0);
        advance();
        sample();
        check("bp_next_grant", 32'(req_ready), 32'b1000);
        advance();
        req_valid[3] = 1'b0;
        wait_rsp(3, lat);
        check("bp_req3_latency", 32'(lat), 32'd3);
        advance();
        rsp_ready = '1;

        // Reset during EXEC abandons the operation
        set_req(0, DIV, 8'd100, 8'd7);
        sample();
        advance();
        req_valid[0] = 1'b0;
        check("exec_started", 32'(alu_start), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_alu", {7'd0, alu_start, alu_a, alu_b, 5'd0, alu_mode}, 32'd0);
        check("mid_rst_rsp", {15'd0, rsp_dz, rsp_data, 4'd0, rsp_valid}, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        sb.delete();
        advance();
        advance();
        reset_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (rsp_valid != '0) cnt++;
            advance();
        end
        check("no_stale_rsp", 32'(cnt), 32'd0);
        do_single(0, ADD, 8'd1, 8'd1, 3, 1);

        // Boundary values and unknown opcode
        do_single(1, 3'd6, 8'h5A, 8'h0F, 3, 1);
        do_single(3, ADD, 8'd200, 8'd100, 3, 1);
        do_single(2, DIV, 8'd100, 8'd7, 3, 1);
        do_single(0, MOD, 8'd100, 8'd7, 3, 1);
        do_single(1, MOD, 8'd0, 8'd0, 1, 0);
        check("sb_empty", 32'(sb.size()), 32'd0);

`ifdef ALU_SCHED_STATS_EN
        do_reset();
        check("stats_rst_op", 32'(op_count), 32'd0);
        check("stats_rst_dz", 32'(dz_count), 32'd0);
        do_single(0, ADD, 8'd1, 8'd2, 3, 1);
        do_single(1, SUB, 8'd9, 8'd2, 3, 1);
        do_single(2, MUL, 8'd3, 8'd3, 3, 1);
        do_single(3, DIV, 8'd7, 8'd0, 1, 0);
        check("stats_op_count", 32'(op_count), 32'd4);
        check("stats_dz_count", 32'(dz_count), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_alu_rr_scheduler
`default_nettype wire
